// File: rtl/stream_mux_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//   Shared types and helpers for the stream_mux_arb slice.
//   - mux_mode_e : how the output channel is chosen
//                  (external select, fixed priority, round-robin)
//   - clog2_min1 : index width for a channel count, never less than 1 bit
// ----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        MUX_SEL,
        MUX_PRIO,
        MUX_RR
    } mux_mode_e;

    // A single channel still needs a 1-bit index so that sel/out_ch exist.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mux_pkg

// File: rtl/stream_mux_arb_if.sv
// ----------------------------------------------------------------------------
// stream_mux_arb_if
//   Bundle of the N:1 stream selector's producer and consumer handshakes.
//   Ports (all logic):
//     sel       CH_W          channel select (external-select mode only)
//     in_valid  N_CH          per-channel request
//     in_data   N_CH*DAT_W    packed, channel i at [i*DAT_WIDTH +: DAT_WIDTH]
//     in_ready  N_CH          per-channel accept, one-hot or zero
//     out_valid 1             output register holds a word
//     out_data  DAT_WIDTH     registered selected data
//     out_ch    CH_W          channel index of out_data
//     out_ready 1             downstream accept
//   Modports:
//     master : the environment (producers + consumer) driving the selector
//     slave  : the selector itself
// ----------------------------------------------------------------------------
interface stream_mux_arb_if
    import mux_pkg::*;
#(
    parameter int DAT_WIDTH = 32,
    parameter int N_CH      = 4
);
    localparam int CH_W = clog2_min1(N_CH);

    logic [CH_W-1:0]           sel;
    logic [N_CH-1:0]           in_valid;
    logic [N_CH*DAT_WIDTH-1:0] in_data;
    logic [N_CH-1:0]           in_ready;
    logic                      out_valid;
    logic [DAT_WIDTH-1:0]      out_data;
    logic [CH_W-1:0]           out_ch;
    logic                      out_ready;

    modport master (
        output sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface : stream_mux_arb_if

// File: rtl/stream_mux_arb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotating-priority arbiter. Scans req starting at ptr,
//   wrapping modulo N_CH, and grants the first asserted request.
//   With ptr tied to zero it degenerates to fixed priority (ch0 highest).
//   Ports:
//     req    in   N_CH   request vector
//     ptr    in   CH_W   first index to consider (must be < N_CH)
//     grant  out  N_CH   one-hot grant, zero when no request
//     idx    out  CH_W   binary index of the granted channel (0 if none)
// ----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);

    logic [CH_W:0]   cand_wide;
    logic [CH_W-1:0] cand;
    logic            found;

    always_comb begin
        grant     = '0;
        idx       = '0;
        found     = 1'b0;
        cand_wide = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            // ptr + i folded back into [0, N_CH): one extra bit avoids overflow.
            cand_wide = {1'b0, ptr} + (CH_W+1)'(i);
            if (cand_wide >= (CH_W+1)'(N_CH)) begin
                cand_wide = cand_wide - (CH_W+1)'(N_CH);
            end
            cand = cand_wide[CH_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/stream_mux_arb.sv
// ----------------------------------------------------------------------------
// stream_mux_arb
//   N:1 stream selector with per-channel valid/ready and one registered
//   output stage. The winning channel comes from an external select, a fixed
//   priority or a round-robin pointer, depending on MODE. One word per cycle
//   is sustained while out_ready is high; the output word is held under
//   back-pressure.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset
//     bus    slave modport of stream_mux_arb_if
//            (sel, in_valid, in_data, in_ready,
//             out_valid, out_data, out_ch, out_ready)
// ----------------------------------------------------------------------------
module stream_mux_arb
    import mux_pkg::*;
#(
    parameter int        DAT_WIDTH = 32,
    parameter int        N_CH      = 4,
    parameter mux_mode_e MODE      = MUX_RR,
    localparam int       CH_W      = clog2_min1(N_CH)
) (
    input logic              clk,
    input logic              rst_n,
    stream_mux_arb_if.slave  bus
);

    if (N_CH < 1) begin : g_bad_nch
        $error("stream_mux_arb: N_CH must be at least 1");
    end
    if (MODE != MUX_SEL && MODE != MUX_PRIO && MODE != MUX_RR) begin : g_bad_mode
        $error("stream_mux_arb: MODE is not a mux_mode_e value");
    end

    logic [N_CH-1:0]      arb_grant;
    logic [CH_W-1:0]      arb_idx;
    logic [CH_W-1:0]      arb_ptr;
    logic [CH_W-1:0]      rr_ptr;

    logic [N_CH-1:0]      grant;
    logic [CH_W-1:0]      gidx;
    logic                 load_en;
    logic [DAT_WIDTH-1:0] sel_data;

    logic                 vld_p1;
    logic [DAT_WIDTH-1:0] data_p1;
    logic [CH_W-1:0]      ch_p1;

    // Fixed priority is the rotating arbiter with the pointer pinned at 0.
    assign arb_ptr = (MODE == MUX_RR) ? rr_ptr : '0;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // ---- stage p0: grant and data select (combinational) ----
    // Grant never looks at out_ready; back-pressure is applied only through
    // load_en on in_ready and on the register enable.
    always_comb begin
        grant = '0;
        gidx  = '0;
        if (MODE == MUX_SEL) begin
            // Out-of-range select grants nothing and so accepts nothing.
            if (int'(bus.sel) < N_CH) begin
                grant[bus.sel] = bus.in_valid[bus.sel];
                gidx           = bus.sel;
            end
        end else begin
            grant = arb_grant;
            gidx  = arb_idx;
        end
    end

    // AND-OR over the one-hot grant keeps the data path free of priority logic.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_data = sel_data
                     | (bus.in_data[i*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{grant[i]}});
        end
    end

    // The register can take a word when it is empty or being drained now.
    assign load_en = !vld_p1 || bus.out_ready;

    // rst_n gates in_ready so nothing is acknowledged while reset is held.
    assign bus.in_ready = grant & {N_CH{load_en & rst_n}};

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
        end else if (load_en) begin
            if (|grant) begin
                vld_p1  <= 1'b1;
                data_p1 <= sel_data;
                ch_p1   <= gidx;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances only on an actual transfer, to the
    // channel after the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (MODE == MUX_RR && load_en && (|grant)) begin
            rr_ptr <= (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_ch    = ch_p1;

endmodule : stream_mux_arb

// File: tb/tb_stream_mux_arb.sv
// ----------------------------------------------------------------------------
// tb_stream_mux_arb
//   Directed bench for stream_mux_arb. Four instances cover external select
//   (3 channels), fixed priority (4), round-robin (4) and a single channel.
//   Expected output words are queued when stimulus is applied and popped
//   when the selected instance presents its registered output.
// ----------------------------------------------------------------------------
module tb_stream_mux_arb;
    import mux_pkg::*;

    localparam int DW = 16;

    logic clk;
    logic rst_n;

    stream_mux_arb_if #(.DAT_WIDTH(DW), .N_CH(3)) if_sel  ();
    stream_mux_arb_if #(.DAT_WIDTH(DW), .N_CH(4)) if_prio ();
    stream_mux_arb_if #(.DAT_WIDTH(DW), .N_CH(4)) if_rr   ();
    stream_mux_arb_if #(.DAT_WIDTH(DW), .N_CH(1)) if_one  ();

    stream_mux_arb #(.DAT_WIDTH(DW), .N_CH(3), .MODE(MUX_SEL))  u_sel  (.clk(clk), .rst_n(rst_n), .bus(if_sel));
    stream_mux_arb #(.DAT_WIDTH(DW), .N_CH(4), .MODE(MUX_PRIO)) u_prio (.clk(clk), .rst_n(rst_n), .bus(if_prio));
    stream_mux_arb #(.DAT_WIDTH(DW), .N_CH(4), .MODE(MUX_RR))   u_rr   (.clk(clk), .rst_n(rst_n), .bus(if_rr));
    stream_mux_arb #(.DAT_WIDTH(DW), .N_CH(1), .MODE(MUX_SEL))  u_one  (.clk(clk), .rst_n(rst_n), .bus(if_one));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [3:0]    ch;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [3:0] ch);
        exp_t e;
        e.d  = d;
        e.ch = ch;
        q.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic vld,
                            input logic [DW-1:0] d, input logic [3:0] ch);
        exp_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed a checkpoint, expected a queued word", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_vld"},  {31'd0, vld}, 32'd1);
            chk({tag, "_data"}, {16'd0, d},   {16'd0, e.d});
            chk({tag, "_ch"},   {28'd0, ch},  {28'd0, e.ch});
        end
    endtask

    // Drive point: just after the rising edge, outputs then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not reach its end");
    end

    initial begin
        rst_n = 1'b0;
        if_sel.sel  = '0; if_sel.in_valid  = '0; if_sel.in_data  = '0; if_sel.out_ready  = 1'b0;
        if_prio.sel = '0; if_prio.in_valid = '0; if_prio.in_data = '0; if_prio.out_ready = 1'b0;
        if_rr.sel   = '0; if_rr.in_valid   = '0; if_rr.in_data   = '0; if_rr.out_ready   = 1'b0;
        if_one.sel  = '0; if_one.in_valid  = '0; if_one.in_data  = '0; if_one.out_ready  = 1'b0;

        tick();
        tick();
        chk("rst_rr_vld",  {31'd0, if_rr.out_valid}, 32'd0);
        chk("rst_rr_data", {16'd0, if_rr.out_data},  32'd0);
        chk("rst_rr_ch",   {30'd0, if_rr.out_ch},    32'd0);
        chk("rst_sel_vld", {31'd0, if_sel.out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // External select, 3 channels: sel=2 picks C, then sel=3 accepts nothing.
        if_sel.in_data   = {16'h00C2, 16'h00B1, 16'h00A0};
        if_sel.in_valid  = 3'b111;
        if_sel.out_ready = 1'b1;
        if_sel.sel       = 2'd2;
        #1;
        chk("sel_ready", {29'd0, if_sel.in_ready}, 32'b100);
        push_exp(16'h00C2, 4'd2);
        tick();
        sb_check("sel_out", if_sel.out_valid, if_sel.out_data, {2'd0, if_sel.out_ch});
        if_sel.sel = 2'd3;
        #1;
        chk("sel_oob_ready", {29'd0, if_sel.in_ready}, 32'd0);
        tick();
        chk("sel_oob_vld",  {31'd0, if_sel.out_valid}, 32'd0);
        chk("sel_oob_hold", {16'd0, if_sel.out_data},  32'h00C2);
        if_sel.in_valid = '0;

        // Fixed priority: ch1 beats ch3 every cycle.
        if_prio.in_data   = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        if_prio.in_valid  = 4'b1010;
        if_prio.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("prio_ready", {28'd0, if_prio.in_ready}, 32'b0010);
            push_exp(16'h1001, 4'd1);
            tick();
            sb_check("prio_out", if_prio.out_valid, if_prio.out_data, {2'd0, if_prio.out_ch});
        end
        if_prio.in_valid = '0;

        // Round-robin with all requests held: 0,1,2,3,0 back to back.
        if_rr.in_data   = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
        if_rr.in_valid  = 4'b1111;
        if_rr.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", {28'd0, if_rr.in_ready}, 32'd1 << (k % 4));
            push_exp(16'h2000 + 16'(k % 4), 4'(k % 4));
            tick();
            sb_check("rr_out", if_rr.out_valid, if_rr.out_data, {2'd0, if_rr.out_ch});
        end

        // Back-pressure: output held, nothing accepted, pointer frozen at 1.
        if_rr.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", {28'd0, if_rr.in_ready}, 32'd0);
            tick();
            chk("bp_vld",  {31'd0, if_rr.out_valid}, 32'd1);
            chk("bp_data", {16'd0, if_rr.out_data},  32'h2000);
            chk("bp_ch",   {30'd0, if_rr.out_ch},    32'd0);
        end
        if_rr.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, if_rr.in_ready}, 32'b0010);
        push_exp(16'h2001, 4'd1);
        tick();
        sb_check("bp_release_out", if_rr.out_valid, if_rr.out_data, {2'd0, if_rr.out_ch});

        // Drain: one word on ch2, then the register empties and keeps its data.
        if_rr.in_valid = 4'b0100;
        #1;
        chk("drain_ready", {28'd0, if_rr.in_ready}, 32'b0100);
        push_exp(16'h2002, 4'd2);
        tick();
        sb_check("drain_out", if_rr.out_valid, if_rr.out_data, {2'd0, if_rr.out_ch});
        if_rr.in_valid = '0;
        tick();
        chk("drain_vld",  {31'd0, if_rr.out_valid}, 32'd0);
        chk("drain_data", {16'd0, if_rr.out_data},  32'h2002);
        chk("drain_ch",   {30'd0, if_rr.out_ch},    32'd2);

        // Reset mid-stream: word dropped at once, pointer back to 0.
        if_rr.in_valid = 4'b1111;
        #1;
        chk("pre_rst_ready", {28'd0, if_rr.in_ready}, 32'b1000);
        push_exp(16'h2003, 4'd3);
        tick();
        sb_check("pre_rst_out3", if_rr.out_valid, if_rr.out_data, {2'd0, if_rr.out_ch});
        chk("pre_rst_ready0", {28'd0, if_rr.in_ready}, 32'b0001);
        push_exp(16'h2000, 4'd0);
        tick();
        sb_check("pre_rst_out0", if_rr.out_valid, if_rr.out_data, {2'd0, if_rr.out_ch});
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld",   {31'd0, if_rr.out_valid}, 32'd0);
        chk("async_rst_data",  {16'd0, if_rr.out_data},  32'd0);
        chk("async_rst_ready", {28'd0, if_rr.in_ready},  32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {28'd0, if_rr.in_ready}, 32'b0001);
        push_exp(16'h2000, 4'd0);
        tick();
        sb_check("post_rst_out", if_rr.out_valid, if_rr.out_data, {2'd0, if_rr.out_ch});
        if_rr.in_valid = '0;

        // Single channel: plain pipeline register; sel != 0 blocks.
        if_one.in_data   = 16'h3333;
        if_one.in_valid  = 1'b1;
        if_one.out_ready = 1'b1;
        if_one.sel       = 1'b0;
        #1;
        chk("one_ready", {31'd0, if_one.in_ready}, 32'd1);
        push_exp(16'h3333, 4'd0);
        tick();
        sb_check("one_out", if_one.out_valid, if_one.out_data, {3'd0, if_one.out_ch});
        if_one.sel = 1'b1;
        #1;
        chk("one_blocked_ready", {31'd0, if_one.in_ready}, 32'd0);
        tick();
        chk("one_blocked_vld", {31'd0, if_one.out_valid}, 32'd0);

        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_stream_mux_arb
